axi_master_arbiter: RTL and testbench

Two-requester arbiter that shares one axi_master user-side port, for example between the instruction-fetch/loader path (requester 0) and the data/MMIO path (requester 1).
It selects one pending read or write per transaction and registers the address, data and strobe toward the master.
It sequences the master's single-cycle re/we issue and routes the completion pulses and read data back to the granted requester only.

---
 rtl/axi_master_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_axi_master_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_arbiter.sv
// Two-requester arbiter in front of a single axi_master user port: picks one
// read or write per transaction, registers its payload and routes completions back.
module axi_master_arbiter #(
    parameter bit          RR_ENABLE      = 1'b1,
    parameter int unsigned AXI_ADDRW      = 32,
    parameter int unsigned AXI_DATAW      = 32,
    parameter int unsigned AXI_DATAW_BYTE = AXI_DATAW / 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      re0,
    input  logic                      re1,
    input  logic                      we0,
    input  logic                      we1,
    input  logic [AXI_ADDRW-1:0]      araddr0,
    input  logic [AXI_ADDRW-1:0]      araddr1,
    input  logic [AXI_ADDRW-1:0]      awaddr0,
    input  logic [AXI_ADDRW-1:0]      awaddr1,
    input  logic [AXI_DATAW-1:0]      wdata0,
    input  logic [AXI_DATAW-1:0]      wdata1,
    input  logic [AXI_DATAW_BYTE-1:0] wstrb0,
    input  logic [AXI_DATAW_BYTE-1:0] wstrb1,
    output logic [AXI_DATAW-1:0]      rdata0,
    output logic [AXI_DATAW-1:0]      rdata1,
    output logic                      r_success0,
    output logic                      r_success1,
    output logic                      r_timeout0,
    output logic                      r_timeout1,
    output logic                      w_success0,
    output logic                      w_success1,
    output logic                      re,
    output logic                      we,
    output logic [AXI_ADDRW-1:0]      araddr_in,
    output logic [AXI_ADDRW-1:0]      awaddr_in,
    output logic [AXI_DATAW-1:0]      wdata_in,
    output logic [AXI_DATAW_BYTE-1:0] wstrb_in,
    input  logic [AXI_DATAW-1:0]      rdata_out,
    input  logic                      r_success,
    input  logic                      r_timeout,
    input  logic                      w_success,
    output logic                      busy,
    output logic                      grant_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                    state_q,  state_d;
    logic                      grant_q,  grant_d;
    logic                      rd_q,     rd_d;
    logic                      last_q,   last_d;
    logic                      busy_q,   busy_d;
    logic                      re_q,     re_d;
    logic                      we_q,     we_d;
    logic [AXI_ADDRW-1:0]      araddr_q, araddr_d;
    logic [AXI_ADDRW-1:0]      awaddr_q, awaddr_d;
    logic [AXI_DATAW-1:0]      wdata_q,  wdata_d;
    logic [AXI_DATAW_BYTE-1:0] wstrb_q,  wstrb_d;
    logic [AXI_DATAW-1:0]      rdata0_q, rdata0_d;
    logic [AXI_DATAW-1:0]      rdata1_q, rdata1_d;
    logic                      rs0_q, rs0_d, rs1_q, rs1_d;
    logic                      rt0_q, rt0_d, rt1_q, rt1_d;
    logic                      ws0_q, ws0_d, ws1_q, ws1_d;

    logic pend0, pend1, pick, pick_rd;

    // Requester choice for this IDLE cycle; ties go to the one not served last.
    always_comb begin
        pend0 = re0 | we0;
        pend1 = re1 | we1;
        if (pend0 && pend1) begin
            pick = RR_ENABLE ? ~last_q : 1'b0;
        end else begin
            pick = pend1;
        end
        pick_rd = pick ? re1 : re0;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rd_d     = rd_q;
        last_d   = last_q;
        araddr_d = araddr_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        re_d     = 1'b0;
        we_d     = 1'b0;
        rs0_d    = 1'b0;
        rs1_d    = 1'b0;
        rt0_d    = 1'b0;
        rt1_d    = 1'b0;
        ws0_d    = 1'b0;
        ws1_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pend0 || pend1) begin
                    grant_d  = pick;
                    rd_d     = pick_rd;
                    araddr_d = pick ? araddr1 : araddr0;
                    awaddr_d = pick ? awaddr1 : awaddr0;
                    wdata_d  = pick ? wdata1  : wdata0;
                    wstrb_d  = pick ? wstrb1  : wstrb0;
                    re_d     = pick_rd;
                    we_d     = ~pick_rd;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                // Success beats timeout; completions of the other kind are ignored.
                if (rd_q) begin
                    if (r_success) begin
                        if (grant_q) begin
                            rdata1_d = rdata_out;
                            rs1_d    = 1'b1;
                        end else begin
                            rdata0_d = rdata_out;
                            rs0_d    = 1'b1;
                        end
                        state_d = S_DONE;
                    end else if (r_timeout) begin
                        rt1_d   = grant_q;
                        rt0_d   = ~grant_q;
                        state_d = S_DONE;
                    end
                end else if (w_success) begin
                    ws1_d   = grant_q;
                    ws0_d   = ~grant_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_d  = grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            grant_q  <= 1'b0;
            rd_q     <= 1'b0;
            last_q   <= 1'b1;
            busy_q   <= 1'b0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            araddr_q <= '0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            rs0_q    <= 1'b0;
            rs1_q    <= 1'b0;
            rt0_q    <= 1'b0;
            rt1_q    <= 1'b0;
            ws0_q    <= 1'b0;
            ws1_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rd_q     <= rd_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            re_q     <= re_d;
            we_q     <= we_d;
            araddr_q <= araddr_d;
            awaddr_q <= awaddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            rs0_q    <= rs0_d;
            rs1_q    <= rs1_d;
            rt0_q    <= rt0_d;
            rt1_q    <= rt1_d;
            ws0_q    <= ws0_d;
            ws1_q    <= ws1_d;
        end
    end

    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign r_success0 = rs0_q;
    assign r_success1 = rs1_q;
    assign r_timeout0 = rt0_q;
    assign r_timeout1 = rt1_q;
    assign w_success0 = ws0_q;
    assign w_success1 = ws1_q;
    assign re         = re_q;
    assign we         = we_q;
    assign araddr_in  = araddr_q;
    assign awaddr_in  = awaddr_q;
    assign wdata_in   = wdata_q;
    assign wstrb_in   = wstrb_q;
    assign busy       = busy_q;
    assign grant_id   = grant_q;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter: a round-robin and a fixed-priority
// instance share stimulus; issued transactions are matched against a queue.
module tb_axi_master_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        re0, re1, we0, we1;
    logic [31:0] araddr0, araddr1, awaddr0, awaddr1, wdata0, wdata1;
    logic [3:0]  wstrb0, wstrb1;
    logic [31:0] rdata_out;
    logic        r_success, r_timeout, w_success;

    logic [31:0] rr_rdata0, rr_rdata1, rr_araddr_in, rr_awaddr_in, rr_wdata_in;
    logic [3:0]  rr_wstrb_in;
    logic        rr_r_success0, rr_r_success1, rr_r_timeout0, rr_r_timeout1;
    logic        rr_w_success0, rr_w_success1, rr_re, rr_we, rr_busy, rr_grant_id;

    logic [31:0] fp_rdata0, fp_rdata1, fp_araddr_in, fp_awaddr_in, fp_wdata_in;
    logic [3:0]  fp_wstrb_in;
    logic        fp_r_success0, fp_r_success1, fp_r_timeout0, fp_r_timeout1;
    logic        fp_w_success0, fp_w_success1, fp_re, fp_we, fp_busy, fp_grant_id;

    axi_master_arbiter #(.RR_ENABLE(1'b1)) dut_rr (
        .clk(clk), .rst(rst),
        .re0(re0), .re1(re1), .we0(we0), .we1(we1),
        .araddr0(araddr0), .araddr1(araddr1), .awaddr0(awaddr0), .awaddr1(awaddr1),
        .wdata0(wdata0), .wdata1(wdata1), .wstrb0(wstrb0), .wstrb1(wstrb1),
        .rdata0(rr_rdata0), .rdata1(rr_rdata1),
        .r_success0(rr_r_success0), .r_success1(rr_r_success1),
        .r_timeout0(rr_r_timeout0), .r_timeout1(rr_r_timeout1),
        .w_success0(rr_w_success0), .w_success1(rr_w_success1),
        .re(rr_re), .we(rr_we),
        .araddr_in(rr_araddr_in), .awaddr_in(rr_awaddr_in),
        .wdata_in(rr_wdata_in), .wstrb_in(rr_wstrb_in),
        .rdata_out(rdata_out), .r_success(r_success), .r_timeout(r_timeout),
        .w_success(w_success), .busy(rr_busy), .grant_id(rr_grant_id)
    );

    axi_master_arbiter #(.RR_ENABLE(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .re0(re0), .re1(re1), .we0(we0), .we1(we1),
        .araddr0(araddr0), .araddr1(araddr1), .awaddr0(awaddr0), .awaddr1(awaddr1),
        .wdata0(wdata0), .wdata1(wdata1), .wstrb0(wstrb0), .wstrb1(wstrb1),
        .rdata0(fp_rdata0), .rdata1(fp_rdata1),
        .r_success0(fp_r_success0), .r_success1(fp_r_success1),
        .r_timeout0(fp_r_timeout0), .r_timeout1(fp_r_timeout1),
        .w_success0(fp_w_success0), .w_success1(fp_w_success1),
        .re(fp_re), .we(fp_we),
        .araddr_in(fp_araddr_in), .awaddr_in(fp_awaddr_in),
        .wdata_in(fp_wdata_in), .wstrb_in(fp_wstrb_in),
        .rdata_out(rdata_out), .r_success(r_success), .r_timeout(r_timeout),
        .w_success(w_success), .busy(fp_busy), .grant_id(fp_grant_id)
    );

    typedef struct {
        logic        id;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic id, input logic rd, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
        exp_t e;
        e.id = id; e.rd = rd; e.addr = addr; e.data = data; e.strb = strb;
        sb.push_back(e);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Every issue pulse from the round-robin instance consumes one expected grant.
    always @(negedge clk) begin
        if (rr_re === 1'b1 || rr_we === 1'b1) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL sb_unexpected_issue: observed grant %0d with empty queue", rr_grant_id);
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_grant", 64'(rr_grant_id), 64'(e.id));
                check("sb_kind_re", 64'(rr_re), 64'(e.rd));
                check("sb_kind_we", 64'(rr_we), 64'(!e.rd));
                check("sb_addr", 64'(e.rd ? rr_araddr_in : rr_awaddr_in), 64'(e.addr));
                if (!e.rd) check("sb_wpayload", 64'({rr_wstrb_in, rr_wdata_in}), 64'({e.strb, e.data}));
            end
        end
    end

    initial begin
        rst = 1'b0;
        re0 = 0; re1 = 0; we0 = 0; we1 = 0;
        araddr0 = '0; araddr1 = '0; awaddr0 = '0; awaddr1 = '0;
        wdata0 = '0; wdata1 = '0; wstrb0 = '0; wstrb1 = '0;
        rdata_out = '0; r_success = 0; r_timeout = 0; w_success = 0;
        step(2);
        check("rst_busy", 64'(rr_busy), 0);
        check("rst_grant", 64'(rr_grant_id), 0);
        check("rst_issue", 64'({rr_re, rr_we}), 0);
        check("rst_rdata", 64'({rr_rdata0, rr_rdata1}), 0);
        check("rst_addr", 64'({rr_araddr_in, rr_awaddr_in}), 0);
        rst = 1'b1;
        step();

        // Single read from requester 0, completion at cycle 4.
        re0 = 1; araddr0 = 32'h100;
        push(1'b0, 1'b1, 32'h100, 32'h0, 4'h0);
        step();
        check("t1_re", 64'(rr_re), 1);
        check("t1_araddr", 64'(rr_araddr_in), 64'h100);
        check("t1_busy", 64'(rr_busy), 1);
        step();
        check("t1_re_once", 64'(rr_re), 0);
        step(2);
        r_success = 1; rdata_out = 32'hDEADBEEF;
        step();
        r_success = 0; re0 = 0;
        check("t1_rs0", 64'(rr_r_success0), 1);
        check("t1_rdata0", 64'(rr_rdata0), 64'hDEADBEEF);
        check("t1_rdata1", 64'(rr_rdata1), 0);
        check("t1_req1_quiet", 64'({rr_r_success1, rr_r_timeout1, rr_w_success1}), 0);
        check("t1_fp_rdata0", 64'(fp_rdata0), 64'hDEADBEEF);
        step();
        check("t1_rs0_drop", 64'(rr_r_success0), 0);
        check("t1_idle", 64'(rr_busy), 0);

        // Write from requester 1 with a spurious read completion during WAIT.
        we1 = 1; awaddr1 = 32'h2000; wdata1 = 32'h12345678; wstrb1 = 4'b0011;
        push(1'b1, 1'b0, 32'h2000, 32'h12345678, 4'b0011);
        step();
        check("t4_we", 64'(rr_we), 1);
        check("t4_grant", 64'(rr_grant_id), 1);
        step();
        check("t4_we_once", 64'(rr_we), 0);
        r_success = 1; rdata_out = 32'h0BAD0BAD;
        step();
        r_success = 0;
        check("t4_spurious_busy", 64'(rr_busy), 1);
        check("t4_spurious_pulses", 64'({rr_r_success0, rr_r_success1, rr_w_success1}), 0);
        check("t4_rdata1_kept", 64'(rr_rdata1), 0);
        check("t4_payload_held", 64'({rr_wstrb_in, rr_wdata_in}), 64'({4'b0011, 32'h12345678}));
        w_success = 1;
        step();
        w_success = 0; we1 = 0;
        check("t4_ws1", 64'(rr_w_success1), 1);
        check("t4_ws0", 64'(rr_w_success0), 0);
        check("t4_awaddr_held", 64'(rr_awaddr_in), 64'h2000);
        step();
        check("t4_ws1_drop", 64'(rr_w_success1), 0);
        check("t4_grant_hold", 64'(rr_grant_id), 1);

        // Read timeout, completed in the same cycle as the issue pulse.
        re0 = 1; araddr0 = 32'h300;
        push(1'b0, 1'b1, 32'h300, 32'h0, 4'h0);
        step();
        r_timeout = 1; rdata_out = 32'h55;
        step();
        r_timeout = 0; re0 = 0;
        check("t5_rt0", 64'(rr_r_timeout0), 1);
        check("t5_rs0", 64'(rr_r_success0), 0);
        check("t5_rdata0_kept", 64'(rr_rdata0), 64'hDEADBEEF);
        check("t5_rt1", 64'(rr_r_timeout1), 0);
        step();
        check("t5_idle", 64'(rr_busy), 0);

        // Success and timeout together: success wins.
        re1 = 1; araddr1 = 32'h400;
        push(1'b1, 1'b1, 32'h400, 32'h0, 4'h0);
        step(2);
        r_success = 1; r_timeout = 1; rdata_out = 32'hCAFEF00D;
        step();
        r_success = 0; r_timeout = 0; re1 = 0;
        check("t5b_rs1", 64'(rr_r_success1), 1);
        check("t5b_rt1", 64'(rr_r_timeout1), 0);
        check("t5b_rdata1", 64'(rr_rdata1), 64'hCAFEF00D);
        step();

        // Both requesting continuously: alternation vs fixed priority.
        re0 = 1; araddr0 = 32'hA00;
        we1 = 1; awaddr1 = 32'hB00; wdata1 = 32'h11; wstrb1 = 4'hF;
        for (int i = 0; i < 6; i++) begin
            if (i[0]) push(1'b1, 1'b0, 32'hB00, 32'h11, 4'hF);
            else      push(1'b0, 1'b1, 32'hA00, 32'h0, 4'h0);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            check("t2_rr_grant", 64'(rr_grant_id), 64'(i[0]));
            check("t3_fp_grant", 64'(fp_grant_id), 0);
            r_success = 1; w_success = 1; rdata_out = 32'h100 + 32'(i);
            step();
            r_success = 0; w_success = 0;
            if (i[0]) check("t2_rr_wpulse", 64'(rr_w_success1), 1);
            else      check("t2_rr_rpulse", 64'(rr_r_success0), 1);
            check("t3_fp_rpulse", 64'(fp_r_success0), 1);
            step();
        end
        re0 = 0; we1 = 0;
        step();
        check("t2_idle", 64'(rr_busy), 0);
        check("t2_rr_rdata0", 64'(rr_rdata0), 64'h104);
        check("t3_fp_rdata0", 64'(fp_rdata0), 64'h105);

        // Reset during WAIT, then a fresh request from requester 1.
        re0 = 1; araddr0 = 32'hC00;
        push(1'b0, 1'b1, 32'hC00, 32'h0, 4'h0);
        step(2);
        rst = 1'b0; re0 = 0;
        step();
        check("t6_busy", 64'(rr_busy), 0);
        check("t6_pulses", 64'({rr_r_success0, rr_r_success1, rr_r_timeout0,
                                rr_r_timeout1, rr_w_success0, rr_w_success1}), 0);
        check("t6_rdata", 64'({rr_rdata0, rr_rdata1}), 0);
        check("t6_araddr", 64'(rr_araddr_in), 0);
        rst = 1'b1; re1 = 1; araddr1 = 32'hD00;
        push(1'b1, 1'b1, 32'hD00, 32'h0, 4'h0);
        step();
        check("t6_re", 64'(rr_re), 1);
        check("t6_grant", 64'(rr_grant_id), 1);
        r_success = 1; rdata_out = 32'h77;
        step();
        r_success = 0; re1 = 0;
        check("t6_rs1", 64'(rr_r_success1), 1);
        check("t6_rdata1", 64'(rr_rdata1), 64'h77);
        step(2);
        check("sb_drained", 64'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
